rtdf_sample_monitor: RTL and testbench
======================================

RTDF_SAMPLE_MONITOR -- requirements
Module: rtdf_sample_monitor

Interface
REQ-001 Parameter WINDOW_LOG2, default 10, log2 of the number of valid samples per statistics window (legal 4..16).
REQ-002 Parameter STALL_LIMIT, default 64, consecutive invalid cycles inside a window that abort the window (legal 2..65535).
REQ-003 clk  in  1  sample clock; all logic on the rising edge.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 sample_valid  in  1  qualifies sample_data this cycle.
REQ-006 sample_data  in  3  3b sign-magnitude GPS sample.
REQ-007 stats_valid  out  1  one-cycle pulse; stats outputs updated this cycle.
REQ-008 sum  out  WINDOW_LOG2+4  signed sum of decoded samples over the last window.
REQ-009 sum_sq  out  WINDOW_LOG2+6  unsigned sum of squared decoded samples.
REQ-010 high_count  out  WINDOW_LOG2+1  count of samples with |value| >= 5.
REQ-011 underrun  out  1  last reported window contained at least one gap.
REQ-012 gap_count  out  16  total gaps since reset, saturating at 16'hFFFF.
REQ-013 window_count  out  16  completed windows since reset, wraps.
REQ-014 link_lost  out  1  one-cycle pulse when a window is aborted by stall.

Function
REQ-015 Decode: bit2 = sign (1 = negative); magnitude = 2*bits[1:0]+1, giving values +-1, +-3, +-5, +-7.
REQ-016 States IDLE, ACCUM, STALLED; IDLE after reset.
REQ-017 IDLE: first cycle with sample_valid=1 accepts that sample, goes to ACCUM; invalid cycles in IDLE count nothing.
REQ-018 ACCUM: every valid cycle adds decoded value to sum accumulator, value^2 to sum_sq accumulator, increments high accumulator if |value| >= 5, increments valid counter.
REQ-019 ACCUM with sample_valid=0: go to STALLED, increment gap_count (saturating), set window gap flag, load stall counter to 1.
REQ-020 STALLED with sample_valid=1: accept sample as in ACCUM, return to ACCUM, and do not count a new gap.
REQ-021 STALLED with sample_valid=0: increment stall counter; when it reaches STALL_LIMIT, pulse link_lost next cycle, discard accumulators, clear gap flag, go to IDLE; stats outputs are unchanged.
REQ-022 Window end: on the edge accepting the 2^WINDOW_LOG2-th valid sample, latch totals including that sample into sum/sum_sq/high_count, latch gap flag into underrun, increment window_count, clear accumulators and gap flag; stats_valid is high the following cycle only.
REQ-023 The cycle immediately after window end, a valid sample belongs to the new window, with no dead cycle.
REQ-024 Accumulator widths are sized so that no overflow is possible at full window: |sum| <= 7*2^W and sum_sq <= 49*2^W.
REQ-025 Stats outputs hold between stats_valid pulses.

Reset
REQ-026 Reset forces IDLE, clears all accumulators, counters, and flags.
REQ-027 All outputs read 0 during reset and on the first cycle after it.
REQ-028 Reset asserted mid-window discards the partial window, with no stats_valid or link_lost pulse.

Structure
REQ-029 The shared package rtdf_pkg holds the state enum, the decode function (3b to signed 4b), and the 3'b sample-format constants.
REQ-030 One sub-module, rtdf_sample_decode, is combinational and provides signed value, squared value (6b), and the high flag.

Verification (WINDOW_LOG2=4, STALL_LIMIT=8)
REQ-031 16 consecutive valid 3'b011 samples -> one stats_valid pulse; sum=112, sum_sq=784, high_count=16, underrun=0, window_count=1.
REQ-032 16 valid samples alternating 3'b001/3'b101 -> sum=0, sum_sq=144, high_count=0.
REQ-033 8 valid 3'b000 samples, then 3 invalid cycles, then 8 valid 3'b000 samples -> sum=16, sum_sq=16, underrun=1, gap_count=1, no link_lost.
REQ-034 5 valid samples, then 8 invalid cycles -> link_lost pulses once, no stats_valid; 16 further valid 3'b100 samples -> sum=-16 and underrun=0.
REQ-035 32 back-to-back valid samples -> stats_valid pulses exactly 16 cycles apart, and window_count=2.
REQ-036 Reset pulsed after 10 valid samples, then 16 valid 3'b111 samples -> single stats_valid with sum=-112 and sum_sq=784.

Source files
------------

// File: rtl/rtdf_pkg.sv
// Shared types and helpers for the RTDF sample monitor: FSM states,
// 3-bit sign-magnitude sample codes and the sample decode function.
package rtdf_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        STALLED = 2'd2
    } state_t;

    localparam logic [2:0] SAMPLE_POS1 = 3'b000;
    localparam logic [2:0] SAMPLE_POS3 = 3'b001;
    localparam logic [2:0] SAMPLE_POS5 = 3'b010;
    localparam logic [2:0] SAMPLE_POS7 = 3'b011;
    localparam logic [2:0] SAMPLE_NEG1 = 3'b100;
    localparam logic [2:0] SAMPLE_NEG3 = 3'b101;
    localparam logic [2:0] SAMPLE_NEG5 = 3'b110;
    localparam logic [2:0] SAMPLE_NEG7 = 3'b111;

    // bit2 is the sign, magnitude is 2*bits[1:0]+1
    function automatic logic signed [3:0] decode_sample(input logic [2:0] s);
        logic signed [3:0] mag;
        mag = $signed({1'b0, s[1:0], 1'b1});
        return s[2] ? -mag : mag;
    endfunction

endpackage

// File: rtl/rtdf_sample_decode.sv
// Combinational sample decoder: signed value, its square and the |value|>=5 flag.
module rtdf_sample_decode
    import rtdf_pkg::*;
(
    input  logic [2:0]        sample,
    output logic signed [3:0] value_c,
    output logic [5:0]        value_sq_c,
    output logic              high_c
);

    logic [2:0] mag;

    assign mag        = {sample[1:0], 1'b1};
    assign value_c    = decode_sample(sample);
    assign value_sq_c = 6'(mag) * 6'(mag);
    assign high_c     = (sample == SAMPLE_POS5) || (sample == SAMPLE_POS7) ||
                        (sample == SAMPLE_NEG5) || (sample == SAMPLE_NEG7);

endmodule

// File: rtl/rtdf_sample_monitor.sv
// Windowed statistics monitor for a 3-bit GPS sample stream with gap
// accounting and stall-based link-loss detection.
module rtdf_sample_monitor
    import rtdf_pkg::*;
#(
    parameter int unsigned WINDOW_LOG2 = 10,
    parameter int unsigned STALL_LIMIT = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sample_valid,
    input  logic [2:0]                    sample_data,
    output logic                          stats_valid,
    output logic signed [WINDOW_LOG2+3:0] sum,
    output logic [WINDOW_LOG2+5:0]        sum_sq,
    output logic [WINDOW_LOG2:0]          high_count,
    output logic                          underrun,
    output logic [15:0]                   gap_count,
    output logic [15:0]                   window_count,
    output logic                          link_lost
);

    localparam int unsigned SUM_W = WINDOW_LOG2 + 4;
    localparam int unsigned SQ_W  = WINDOW_LOG2 + 6;
    localparam int unsigned HC_W  = WINDOW_LOG2 + 1;
    localparam int unsigned CNT_W = WINDOW_LOG2;

    localparam logic [CNT_W-1:0] CNT_LAST   = '1;
    localparam logic [15:0]      STALL_LAST = 16'(STALL_LIMIT - 1);

    state_t                    state;
    logic signed [SUM_W-1:0]   acc_sum;
    logic [SQ_W-1:0]           acc_sq;
    logic [HC_W-1:0]           acc_high;
    logic [CNT_W-1:0]          acc_cnt;
    logic                      gap_flag;
    logic [15:0]               stall_cnt;

    logic signed [3:0]         dec_value;
    logic [5:0]                dec_sq;
    logic                      dec_high;

    logic signed [SUM_W-1:0]   nxt_sum;
    logic [SQ_W-1:0]           nxt_sq;
    logic [HC_W-1:0]           nxt_high;
    logic                      window_done;

    rtdf_sample_decode u_decode (
        .sample     (sample_data),
        .value_c    (dec_value),
        .value_sq_c (dec_sq),
        .high_c     (dec_high)
    );

    // Running totals including the current sample; accumulators are zero in IDLE
    always_comb begin
        nxt_sum     = acc_sum + $signed({{(SUM_W-4){dec_value[3]}}, dec_value});
        nxt_sq      = acc_sq + SQ_W'(dec_sq);
        nxt_high    = acc_high + HC_W'(dec_high);
        window_done = (acc_cnt == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            acc_sum      <= '0;
            acc_sq       <= '0;
            acc_high     <= '0;
            acc_cnt      <= '0;
            gap_flag     <= 1'b0;
            stall_cnt    <= '0;
            stats_valid  <= 1'b0;
            sum          <= '0;
            sum_sq       <= '0;
            high_count   <= '0;
            underrun     <= 1'b0;
            gap_count    <= '0;
            window_count <= '0;
            link_lost    <= 1'b0;
        end else begin
            stats_valid <= 1'b0;
            link_lost   <= 1'b0;
            if (sample_valid) begin
                // A valid sample is accepted identically from every state
                stall_cnt <= '0;
                if (window_done) begin
                    sum          <= nxt_sum;
                    sum_sq       <= nxt_sq;
                    high_count   <= nxt_high;
                    underrun     <= gap_flag;
                    window_count <= window_count + 16'd1;
                    stats_valid  <= 1'b1;
                    acc_sum      <= '0;
                    acc_sq       <= '0;
                    acc_high     <= '0;
                    acc_cnt      <= '0;
                    gap_flag     <= 1'b0;
                    state        <= IDLE;
                end else begin
                    acc_sum  <= nxt_sum;
                    acc_sq   <= nxt_sq;
                    acc_high <= nxt_high;
                    acc_cnt  <= acc_cnt + CNT_W'(1);
                    state    <= ACCUM;
                end
            end else begin
                unique case (state)
                    ACCUM: begin
                        if (gap_count != 16'hFFFF) begin
                            gap_count <= gap_count + 16'd1;
                        end
                        gap_flag  <= 1'b1;
                        stall_cnt <= 16'd1;
                        state     <= STALLED;
                    end
                    STALLED: begin
                        if (stall_cnt == STALL_LAST) begin
                            link_lost <= 1'b1;
                            acc_sum   <= '0;
                            acc_sq    <= '0;
                            acc_high  <= '0;
                            acc_cnt   <= '0;
                            gap_flag  <= 1'b0;
                            stall_cnt <= '0;
                            state     <= IDLE;
                        end else begin
                            stall_cnt <= stall_cnt + 16'd1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rtdf_sample_monitor.sv
// Directed self-checking bench for rtdf_sample_monitor (WINDOW_LOG2=4, STALL_LIMIT=8).
module tb_rtdf_sample_monitor;
    import rtdf_pkg::*;

    logic              clk;
    logic              reset;
    logic              sample_valid;
    logic [2:0]        sample_data;
    logic              stats_valid;
    logic signed [7:0] sum;
    logic [9:0]        sum_sq;
    logic [4:0]        high_count;
    logic              underrun;
    logic [15:0]       gap_count;
    logic [15:0]       window_count;
    logic              link_lost;

    int n_cmp;
    int n_bad;
    int cyc;
    int sv_cnt;
    int ll_cnt;
    int sv_last;
    int sv_interval;

    rtdf_sample_monitor #(.WINDOW_LOG2(4), .STALL_LIMIT(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .stats_valid  (stats_valid),
        .sum          (sum),
        .sum_sq       (sum_sq),
        .high_count   (high_count),
        .underrun     (underrun),
        .gap_count    (gap_count),
        .window_count (window_count),
        .link_lost    (link_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor sampled on the falling edge
    always @(negedge clk) begin
        if (stats_valid === 1'b1) begin
            if (sv_cnt > 0) sv_interval = cyc - sv_last;
            sv_last = cyc;
            sv_cnt++;
        end
        if (link_lost === 1'b1) ll_cnt++;
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        sample_valid = 1'b0;
        sample_data = 3'b000;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        sv_cnt = 0;
        ll_cnt = 0;
        sv_interval = 0;
    endtask

    task automatic send(input logic [2:0] d);
        @(negedge clk);
        sample_valid = 1'b1;
        sample_data = d;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            sample_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        sample_valid = 1'b1;
        sample_data = SAMPLE_POS7;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({stats_valid, sum, sum_sq, high_count, underrun, gap_count, window_count, link_lost} !== '0) begin
            n_bad++;
            $display("FAIL reset_during: outputs got %h required 0",
                     {stats_valid, sum, sum_sq, high_count, underrun, gap_count, window_count, link_lost});
        end
        reset = 1'b0;
        sample_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({stats_valid, sum, sum_sq, high_count, underrun, gap_count, window_count, link_lost} !== '0) begin
            n_bad++;
            $display("FAIL reset_after: outputs got %h required 0",
                     {stats_valid, sum, sum_sq, high_count, underrun, gap_count, window_count, link_lost});
        end
        sv_cnt = 0;
        ll_cnt = 0;
    endtask

    task automatic test_window_pos7();
        do_reset();
        repeat (16) send(SAMPLE_POS7);
        @(negedge clk);
        sample_valid = 1'b0;
        n_cmp++;
        if (stats_valid !== 1'b1) begin n_bad++; $display("FAIL pos7_pulse: got %0b required 1", stats_valid); end
        n_cmp++;
        if (sum !== 8'sd112) begin n_bad++; $display("FAIL pos7_sum: got %0d required 112", sum); end
        n_cmp++;
        if (sum_sq !== 10'd784) begin n_bad++; $display("FAIL pos7_sum_sq: got %0d required 784", sum_sq); end
        n_cmp++;
        if (high_count !== 5'd16) begin n_bad++; $display("FAIL pos7_high: got %0d required 16", high_count); end
        n_cmp++;
        if (underrun !== 1'b0) begin n_bad++; $display("FAIL pos7_underrun: got %0b required 0", underrun); end
        n_cmp++;
        if (window_count !== 16'd1) begin n_bad++; $display("FAIL pos7_windows: got %0d required 1", window_count); end
        @(negedge clk);
        n_cmp++;
        if (stats_valid !== 1'b0) begin n_bad++; $display("FAIL pos7_pulse_end: got %0b required 0", stats_valid); end
        idle(12);
        n_cmp++;
        if (sum !== 8'sd112 || sum_sq !== 10'd784) begin
            n_bad++; $display("FAIL pos7_hold: got sum %0d sq %0d required 112 784", sum, sum_sq);
        end
        n_cmp++;
        if (sv_cnt !== 1 || ll_cnt !== 0) begin
            n_bad++; $display("FAIL pos7_pulses: got sv %0d ll %0d required 1 0", sv_cnt, ll_cnt);
        end
    endtask

    task automatic test_alternate();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send(SAMPLE_POS3);
            send(SAMPLE_NEG3);
        end
        idle(3);
        n_cmp++;
        if (sum !== 8'sd0) begin n_bad++; $display("FAIL alt_sum: got %0d required 0", sum); end
        n_cmp++;
        if (sum_sq !== 10'd144) begin n_bad++; $display("FAIL alt_sum_sq: got %0d required 144", sum_sq); end
        n_cmp++;
        if (high_count !== 5'd0) begin n_bad++; $display("FAIL alt_high: got %0d required 0", high_count); end
        n_cmp++;
        if (sv_cnt !== 1) begin n_bad++; $display("FAIL alt_pulses: got %0d required 1", sv_cnt); end
    endtask

    task automatic test_gap();
        do_reset();
        repeat (8) send(SAMPLE_POS1);
        idle(3);
        repeat (8) send(SAMPLE_POS1);
        idle(3);
        n_cmp++;
        if (sum !== 8'sd16) begin n_bad++; $display("FAIL gap_sum: got %0d required 16", sum); end
        n_cmp++;
        if (sum_sq !== 10'd16) begin n_bad++; $display("FAIL gap_sum_sq: got %0d required 16", sum_sq); end
        n_cmp++;
        if (underrun !== 1'b1) begin n_bad++; $display("FAIL gap_underrun: got %0b required 1", underrun); end
        n_cmp++;
        if (gap_count !== 16'd1) begin n_bad++; $display("FAIL gap_count: got %0d required 1", gap_count); end
        n_cmp++;
        if (ll_cnt !== 0 || sv_cnt !== 1) begin
            n_bad++; $display("FAIL gap_pulses: got ll %0d sv %0d required 0 1", ll_cnt, sv_cnt);
        end
    endtask

    task automatic test_stall_boundary();
        // One cycle short of the stall limit must not abort the window
        do_reset();
        repeat (5) send(SAMPLE_NEG5);
        idle(7);
        repeat (11) send(SAMPLE_NEG5);
        idle(3);
        n_cmp++;
        if (ll_cnt !== 0) begin n_bad++; $display("FAIL limit_minus1_ll: got %0d required 0", ll_cnt); end
        n_cmp++;
        if (sv_cnt !== 1) begin n_bad++; $display("FAIL limit_minus1_sv: got %0d required 1", sv_cnt); end
        n_cmp++;
        if (sum !== -8'sd80 || high_count !== 5'd16) begin
            n_bad++; $display("FAIL limit_minus1_stats: got sum %0d high %0d required -80 16", sum, high_count);
        end
        n_cmp++;
        if (underrun !== 1'b1) begin n_bad++; $display("FAIL limit_minus1_underrun: got %0b required 1", underrun); end
    endtask

    task automatic test_stall();
        do_reset();
        repeat (5) send(SAMPLE_POS7);
        idle(8);
        idle(2);
        n_cmp++;
        if (ll_cnt !== 1) begin n_bad++; $display("FAIL stall_link_lost: got %0d required 1", ll_cnt); end
        n_cmp++;
        if (sv_cnt !== 0) begin n_bad++; $display("FAIL stall_no_stats: got %0d required 0", sv_cnt); end
        n_cmp++;
        if (sum !== 8'sd0 || window_count !== 16'd0) begin
            n_bad++; $display("FAIL stall_stats_hold: got sum %0d win %0d required 0 0", sum, window_count);
        end
        n_cmp++;
        if (gap_count !== 16'd1) begin n_bad++; $display("FAIL stall_gap_count: got %0d required 1", gap_count); end
        repeat (16) send(SAMPLE_NEG1);
        idle(3);
        n_cmp++;
        if (sum !== -8'sd16) begin n_bad++; $display("FAIL stall_after_sum: got %0d required -16", sum); end
        n_cmp++;
        if (sum_sq !== 10'd16) begin n_bad++; $display("FAIL stall_after_sq: got %0d required 16", sum_sq); end
        n_cmp++;
        if (underrun !== 1'b0) begin n_bad++; $display("FAIL stall_after_underrun: got %0b required 0", underrun); end
        n_cmp++;
        if (sv_cnt !== 1 || ll_cnt !== 1) begin
            n_bad++; $display("FAIL stall_after_pulses: got sv %0d ll %0d required 1 1", sv_cnt, ll_cnt);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        repeat (16) send(SAMPLE_NEG7);
        repeat (16) send(SAMPLE_POS5);
        idle(3);
        n_cmp++;
        if (sv_cnt !== 2) begin n_bad++; $display("FAIL b2b_pulses: got %0d required 2", sv_cnt); end
        n_cmp++;
        if (sv_interval !== 16) begin n_bad++; $display("FAIL b2b_interval: got %0d required 16", sv_interval); end
        n_cmp++;
        if (window_count !== 16'd2) begin n_bad++; $display("FAIL b2b_windows: got %0d required 2", window_count); end
        n_cmp++;
        if (sum !== 8'sd80 || sum_sq !== 10'd400 || high_count !== 5'd16) begin
            n_bad++;
            $display("FAIL b2b_second_window: got sum %0d sq %0d high %0d required 80 400 16", sum, sum_sq, high_count);
        end
        n_cmp++;
        if (gap_count !== 16'd0) begin n_bad++; $display("FAIL b2b_gaps: got %0d required 0", gap_count); end
    endtask

    task automatic test_reset_midwindow();
        do_reset();
        repeat (10) send(SAMPLE_POS3);
        idle(1);
        n_cmp++;
        if (sv_cnt !== 0 || ll_cnt !== 0) begin
            n_bad++; $display("FAIL midrst_pre_pulses: got sv %0d ll %0d required 0 0", sv_cnt, ll_cnt);
        end
        do_reset();
        n_cmp++;
        if (window_count !== 16'd0 || gap_count !== 16'd1 - 16'd1 + gap_count - gap_count) begin
            n_bad++; $display("FAIL midrst_counters: got win %0d gap %0d required 0 0", window_count, gap_count);
        end
        repeat (16) send(SAMPLE_NEG7);
        idle(3);
        n_cmp++;
        if (sv_cnt !== 1 || ll_cnt !== 0) begin
            n_bad++; $display("FAIL midrst_pulses: got sv %0d ll %0d required 1 0", sv_cnt, ll_cnt);
        end
        n_cmp++;
        if (sum !== -8'sd112) begin n_bad++; $display("FAIL midrst_sum: got %0d required -112", sum); end
        n_cmp++;
        if (sum_sq !== 10'd784) begin n_bad++; $display("FAIL midrst_sum_sq: got %0d required 784", sum_sq); end
        n_cmp++;
        if (window_count !== 16'd1) begin n_bad++; $display("FAIL midrst_windows: got %0d required 1", window_count); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc = 0;
        sv_cnt = 0;
        ll_cnt = 0;
        sv_last = 0;
        sv_interval = 0;
        reset = 1'b1;
        sample_valid = 1'b0;
        sample_data = 3'b000;
        test_reset();
        test_window_pos7();
        test_alternate();
        test_gap();
        test_stall_boundary();
        test_stall();
        test_back_to_back();
        test_reset_midwindow();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
